// File: rtl/seq_pkg.sv
// Shared constants for the 8-word pattern generator and its checker.
// Both sides take the ROM and sync word from here so they cannot drift apart.
package seq_pkg;

  localparam int SEQ_LEN = 8;
  localparam int IDX_W   = $clog2(SEQ_LEN);

  localparam logic [7:0] SYNC_WORD = 8'hAF;

  localparam logic [7:0] SEQ_ROM [SEQ_LEN] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] idx);
    return SEQ_ROM[idx];
  endfunction

endpackage

// File: rtl/sequence_checker.sv
// Aligns to the repeating generator pattern, flywheels through it once locked,
// and reports completed sequences, byte errors and loss of lock.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             match,
  output logic             err,
  output logic             lock_lost,
  output logic [2:0]       exp_idx,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] seq_count
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       miss_q, miss_d;
  logic             dirty_q, dirty_d;
  logic             locked_q, locked_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;

  logic       hit, wrap, is_sync, loss;
  logic [2:0] miss_inc;

  assign hit      = (in_data == rom_byte(idx_q));
  assign wrap     = (idx_q == IDX_W'(SEQ_LEN - 1));
  assign is_sync  = (in_data == SYNC_WORD);
  assign miss_inc = miss_q + 3'd1;
  // Loss is only ever decided on a mismatching byte, so a match and lock_lost never coincide.
  assign loss     = in_valid && (state_q == LOCKED) && !hit && (miss_inc == 3'(LOSS_THRESH));

  // NOTE: every register lives in this one process with non-blocking assignments,
  // so all comb readers see the pre-edge values regardless of process order.
  // NOTE: reset covers only flops; there is no memory here, the ROM is a constant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEARCH;
      idx_q     <= '0;
      miss_q    <= '0;
      dirty_q   <= 1'b0;
      locked_q  <= 1'b0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      err_cnt_q <= '0;
      seq_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      miss_q    <= miss_d;
      dirty_q   <= dirty_d;
      locked_q  <= locked_d;
      match_q   <= match_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
      err_cnt_q <= err_cnt_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns every variable and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    miss_d  = miss_q;
    dirty_d = dirty_q;
    if (in_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (is_sync) begin
            state_d = TRACK;
            idx_d   = IDX_W'(1);
          end else begin
            idx_d = '0;
          end
        end
        TRACK: begin
          if (hit && wrap) begin
            state_d = LOCKED;
            idx_d   = '0;
            miss_d  = '0;
            dirty_d = 1'b0;
          end else if (hit) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (is_sync) begin
            idx_d = IDX_W'(1);
          end else begin
            state_d = SEARCH;
            idx_d   = '0;
          end
        end
        LOCKED: begin
          idx_d = idx_q + IDX_W'(1);
          if (hit) begin
            miss_d = '0;
          end else begin
            miss_d  = miss_inc;
            dirty_d = 1'b1;
          end
          if (wrap) dirty_d = 1'b0;
          if (loss) begin
            miss_d  = '0;
            dirty_d = 1'b0;
            // A sync word arriving on the losing byte is a head start on reacquisition.
            state_d = is_sync ? TRACK : SEARCH;
            idx_d   = is_sync ? IDX_W'(1) : '0;
          end
        end
        default: begin
          state_d = SEARCH;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    match_d   = 1'b0;
    err_d     = 1'b0;
    lost_d    = loss;
    err_cnt_d = err_cnt_q;
    seq_cnt_d = seq_cnt_q;
    locked_d  = (state_d == LOCKED);
    if (in_valid) begin
      if ((state_q == TRACK && hit && wrap) ||
          (state_q == LOCKED && hit && wrap && !dirty_q)) begin
        match_d   = 1'b1;
        seq_cnt_d = seq_cnt_q + CNT_W'(1);
      end
      if (state_q == LOCKED && !hit) begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign locked    = locked_q;
  assign match     = match_q;
  assign err       = err_q;
  assign lock_lost = lost_q;
  assign exp_idx   = 3'(idx_q);
  assign err_count = err_cnt_q;
  assign seq_count = seq_cnt_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Randomised self-checking bench: two checker instances (16-bit and 4-bit counters)
// compared every cycle against a rule-level reference model.
module tb_sequence_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        locked, match, err, lock_lost;
  logic [2:0]  exp_idx;
  logic [15:0] err_count, seq_count;

  logic        locked_s, match_s, err_s, lock_lost_s;
  logic [2:0]  exp_idx_s;
  logic [3:0]  err_count_s, seq_count_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sequence_checker #(.LOSS_THRESH(3), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .match(match), .err(err), .lock_lost(lock_lost),
    .exp_idx(exp_idx), .err_count(err_count), .seq_count(seq_count)
  );

  sequence_checker #(.LOSS_THRESH(3), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .locked(locked_s), .match(match_s), .err(err_s), .lock_lost(lock_lost_s),
    .exp_idx(exp_idx_s), .err_count(err_count_s), .seq_count(seq_count_s)
  );

  // Reference model: position in the pattern plus a coarse mode.
  localparam int M_SEARCH = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;

  int m_mode, m_pos, m_miss, m_errs, m_seqs;
  bit m_seq_bad, m_match, m_err, m_lost;
  int gen_pos = 0;

  function automatic logic [7:0] golden(input int i);
    case (i % 8)
      0: return 8'hAF;
      1: return 8'hBC;
      2: return 8'hE2;
      3: return 8'h78;
      4: return 8'hFF;
      5: return 8'hE2;
      6: return 8'h0B;
      default: return 8'h8D;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SEARCH; m_pos = 0; m_miss = 0; m_errs = 0; m_seqs = 0;
    m_seq_bad = 0; m_match = 0; m_err = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    bit good;
    m_match = 0; m_err = 0; m_lost = 0;
    if (!v) return;
    good = (d == golden(m_pos));
    if (m_mode == M_SEARCH) begin
      if (d == 8'hAF) begin m_mode = M_TRACK; m_pos = 1; end
      else m_pos = 0;
    end else if (m_mode == M_TRACK) begin
      if (good && m_pos == 7) begin
        m_mode = M_LOCKED; m_pos = 0; m_miss = 0; m_seq_bad = 0;
        m_match = 1; m_seqs++;
      end else if (good) m_pos++;
      else if (d == 8'hAF) m_pos = 1;
      else begin m_mode = M_SEARCH; m_pos = 0; end
    end else begin
      if (good) begin
        m_miss = 0;
        if (m_pos == 7 && !m_seq_bad) begin m_match = 1; m_seqs++; end
      end else begin
        m_err = 1; m_errs++; m_miss++; m_seq_bad = 1;
      end
      if (m_pos == 7) m_seq_bad = 0;
      m_pos = (m_pos + 1) % 8;
      if (m_miss == 3) begin
        m_lost = 1; m_miss = 0; m_seq_bad = 0;
        if (d == 8'hAF) begin m_mode = M_TRACK; m_pos = 1; end
        else begin m_mode = M_SEARCH; m_pos = 0; end
      end
    end
  endtask

  task automatic compare_all();
    check("locked", 32'(locked), 32'(m_mode == M_LOCKED));
    check("match", 32'(match), 32'(m_match));
    check("err", 32'(err), 32'(m_err));
    check("lock_lost", 32'(lock_lost), 32'(m_lost));
    check("exp_idx", 32'(exp_idx), 32'(m_pos));
    check("err_count", 32'(err_count), 32'((m_errs > 65535) ? 65535 : m_errs));
    check("seq_count", 32'(seq_count), 32'(m_seqs % 65536));
    check("err_count_w4", 32'(err_count_s), 32'((m_errs > 15) ? 15 : m_errs));
    check("seq_count_w4", 32'(seq_count_s), 32'(m_seqs % 16));
  endtask

  // Called just after a falling edge; samples on the next falling edge.
  task automatic drive(input bit v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_step(v, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_gen(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, golden(gen_pos));
      gen_pos++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    gen_pos = 0;
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Three clean sequences from the sync word.
    send_gen(8);
    check("lock_after_first_8d", 32'(locked), 32'd1);
    send_gen(16);
    check("clean_seq_count", 32'(seq_count), 32'd3);
    check("clean_err_count", 32'(err_count), 32'd0);

    // Partial start at 78 then a full sequence.
    do_reset();
    gen_pos = 3;
    send_gen(5);
    check("partial_no_lock", 32'(locked), 32'd0);
    send_gen(8);
    check("partial_seq_count", 32'(seq_count), 32'd1);

    // Single corrupted byte while locked.
    send_gen(4);
    drive(1'b1, 8'h00);
    gen_pos++;
    check("corrupt_err_pulse", 32'(err), 32'd1);
    send_gen(3);
    check("corrupt_err_count", 32'(err_count), 32'd1);
    check("corrupt_still_locked", 32'(locked), 32'd1);
    send_gen(8);
    check("corrupt_resume_seq", 32'(seq_count), 32'd2);

    // Three consecutive bad bytes drop lock, then relock.
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b1, 8'h33);
    check("loss_pulse", 32'(lock_lost), 32'd1);
    check("loss_unlocked", 32'(locked), 32'd0);
    check("loss_idx", 32'(exp_idx), 32'd0);
    gen_pos = 0;
    send_gen(8);
    check("relock", 32'(locked), 32'd1);

    // Gapped valid with garbage on idle cycles.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      while ($urandom_range(0, 2) == 0) drive(1'b0, 8'($urandom));
      drive(1'b1, golden(i));
    end
    check("gapped_seq_count", 32'(seq_count), 32'd3);
    check("gapped_err_count", 32'(err_count), 32'd0);

    // Asynchronous reset mid-sequence while locked.
    send_gen(3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_seq", 32'(seq_count), 32'd0);
    check("async_rst_err", 32'(err_count), 32'd0);
    check("async_rst_idx", 32'(exp_idx), 32'd0);
    model_reset();
    gen_pos = 0;
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // Alternate bad/good bytes so lock is kept while errors pile up.
    send_gen(8);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, golden(gen_pos) ^ 8'h55);
      gen_pos++;
      send_gen(1);
    end
    check("sat_w4", 32'(err_count_s), 32'd15);
    check("sat_w16", 32'(err_count), 32'd20);

    // Random fuzz: mostly pattern, with corruption, slips and gaps.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 4) == 0) drive(1'b0, 8'($urandom));
      else if ($urandom_range(0, 15) == 0) begin
        drive(1'b1, 8'($urandom));
        gen_pos++;
      end else begin
        if ($urandom_range(0, 63) == 0) gen_pos = gen_pos + int'($urandom_range(1, 7));
        send_gen(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
